parity_rr_dispatcher: RTL
=========================

// Module: parity_rr_dispatcher
// PURPOSE
//  Controller between the word FIFO and N downstream consumers. Pops FIFO head, checks parity, silently
//  drains bad-parity words (counting them), and shares good words between NUM_REQ requesters round-robin.
//  Stops bad words stalling the FIFO; gives one parity checker + FIFO to several consumers.
// PARAMETERS
//  DATA_WIDTH        8    FIFO word width incl. parity bit (>=2)
//  PARITY_MODE       ODD  parity_mode_t (types_pkg): ODD/EVEN = required total count of ones in the word
//  PARITY_BIT_CHOICE MSB  parity_bit_t (types_pkg): position of parity bit (MSB or LSB)
//  NUM_REQ           4    number of requesters (2..8)
//  CNT_WIDTH         16   width of saturating parity-error counter
// PORTS
//  clk_i        in   1             clock, rising edge
//  rst_ni       in   1             asynchronous active-low reset
//  enable_i     in   1             1: allowed to pop new words from FIFO
//  pop_valid_i  in   1             FIFO presents a word
//  pop_data_i   in   DATA_WIDTH    FIFO head word
//  pop_grant_o  out  1             pop FIFO head this cycle
//  req_i        in   NUM_REQ       requester k wants a word
//  valid_o      out  NUM_REQ       one-hot: word on data_o offered to requester k
//  grant_i      in   NUM_REQ       requester k accepts offered word
//  data_o       out  DATA_WIDTH-1  payload, parity bit stripped
//  err_o        out  1             1-cycle pulse: bad-parity word dropped
//  err_cnt_o    out  CNT_WIDTH     saturating count of dropped words
// BEHAVIOUR
//  Parity: ok = ^pop_data_i == (PARITY_MODE==ODD). Payload = pop_data_i[DATA_WIDTH-2:0] if MSB,
//   pop_data_i[DATA_WIDTH-1:1] if LSB.
//  Reset (async, rst_ni=0): state=IDLE, ptr=0, hold reg=0, err_cnt_o=0; all outputs 0 immediately.
//  FSM states IDLE, HOLD, SEND:
//   IDLE: pop_grant_o = enable_i & pop_valid_i (combinational, same cycle).
//    popped & ok  -> capture payload into hold reg, -> HOLD.
//    popped & bad -> discard, err_o=1 next cycle, err_cnt_o+1 (sat), stay IDLE (one bad word/cycle drained).
//   HOLD: pop_grant_o=0. If |req_i: winner = first k with req_i[k]=1 scanning ptr, ptr+1,... mod NUM_REQ;
//    register winner, -> SEND. Else stay HOLD.
//   SEND: valid_o = onehot(winner), data_o = hold reg. Offer locked: req_i deassert does not withdraw it.
//    grant_i[winner]=1 -> ptr = (winner+1) mod NUM_REQ, -> IDLE. grant_i on other bits ignored.
//  valid_o=0 and data_o=0 outside SEND. err_o=0 except cycle after bad drop.
//  Latency: good word popped cycle T (req present) -> valid_o at T+2; min 3 cycles/good word.
//  enable_i=0: no new pops; word in HOLD/SEND still delivered.
//  err_cnt_o at all-ones holds; err_o still pulses.
//  Reset mid-HOLD/SEND: held word lost (already popped, not re-fetched).
//  No combinational path from req_i/grant_i to pop_grant_o.
// TESTING (DATA_WIDTH=8, ODD, MSB, NUM_REQ=4, CNT_WIDTH=4)
//  1 Reset: rst_ni=0 with pop_valid_i=1, req_i=4'hF -> pop_grant_o, valid_o, err_o, err_cnt_o all 0.
//  2 Good word 8'h01, req_i=4'b0001, grant_i[0] when offered -> pop_grant_o=1 @T, valid_o=4'b0001
//    @T+2, data_o=7'h01, err_cnt_o=0; next win from ptr=1.
//  3 Bad words 8'h03,8'h81,8'h00 back-to-back -> pop_grant_o=1 for 3 cycles, valid_o=0, err_o 3 pulses,
//    err_cnt_o=3.
//  4 req_i=4'hF, 5 good words 8'h02 (ok: ^=1), immediate grants -> winners 0,1,2,3,0; req_i=4'b1010
//    from ptr=1 -> winner 1, then 3.
//  5 17 bad words -> err_cnt_o saturates at 4'hF; err_o pulses all 17 times.
//  6 enable_i=0, pop_valid_i=1 -> pop_grant_o=0; rst_ni=0 during SEND -> valid_o=0 at once, ptr=0.

Source files
------------

// File: rtl/parity_rr_dispatcher.sv
// Pops words from a FIFO, drops bad-parity words with a saturating count, and offers good words
// round-robin to NUM_REQ requesters (pop->offer 2 cycles, offer held until the chosen requester grants).
package types_pkg;
  typedef enum logic {ODD, EVEN} parity_mode_t;
  typedef enum logic {MSB, LSB} parity_bit_t;
endpackage

module parity_rr_dispatcher
  import types_pkg::*;
#(
  parameter int           DATA_WIDTH        = 8,
  parameter parity_mode_t PARITY_MODE       = ODD,
  parameter parity_bit_t  PARITY_BIT_CHOICE = MSB,
  parameter int           NUM_REQ           = 4,
  parameter int           CNT_WIDTH         = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  pop_valid_i,
  input  logic [DATA_WIDTH-1:0] pop_data_i,
  output logic                  pop_grant_o,
  input  logic [NUM_REQ-1:0]    req_i,
  output logic [NUM_REQ-1:0]    valid_o,
  input  logic [NUM_REQ-1:0]    grant_i,
  output logic [DATA_WIDTH-2:0] data_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, HOLD, SEND} state_t;

  state_t                state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         winner;
  logic [DATA_WIDTH-2:0] hold;

  logic                  parity_ok;
  logic [DATA_WIDTH-2:0] payload;
  logic [IW-1:0]         arb;
  logic                  arb_found;
  logic [IW-1:0]         ptr_after;

  assign parity_ok = (^pop_data_i) == (PARITY_MODE == ODD);
  assign payload   = (PARITY_BIT_CHOICE == MSB) ? pop_data_i[DATA_WIDTH-2:0]
                                                : pop_data_i[DATA_WIDTH-1:1];

  // Reset gates the pop request so nothing leaves the FIFO while rst_ni is low.
  assign pop_grant_o = rst_ni & (state == IDLE) & enable_i & pop_valid_i;
  assign valid_o     = (state == SEND) ? (NUM_REQ'(1) << winner) : '0;
  assign data_o      = (state == SEND) ? hold : '0;

  always_comb begin
    int k;
    k         = 0;
    arb       = '0;
    arb_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!arb_found && req_i[IW'(k)]) begin
        arb       = IW'(k);
        arb_found = 1'b1;
      end
    end
  end

  assign ptr_after = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      ptr       <= '0;
      winner    <= '0;
      hold      <= '0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pop_grant_o) begin
            if (parity_ok) begin
              hold  <= payload;
              state <= HOLD;
            end else begin
              err_o <= 1'b1;
              if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
            end
          end
        end
        HOLD: begin
          if (arb_found) begin
            winner <= arb;
            state  <= SEND;
          end
        end
        SEND: begin
          if (grant_i[winner]) begin
            ptr   <= ptr_after;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
